// File: rtl/ysyx_22040386_regfile_sb_if.sv
// Writeback-to-regfile and decode-to-regfile signal bundle.
// The pipeline drives the master side; the register file is the slave.
interface ysyx_22040386_regfile_sb_if;
   logic        i_WB_RegWrite;
   logic [4:0]  i_WB_reg_wr_addr;
   logic [63:0] i_WB_reg_wr_data;
   logic [4:0]  i_ID_rs1_addr;
   logic [4:0]  i_ID_rs2_addr;
   logic [63:0] o_ID_rs1_data;
   logic [63:0] o_ID_rs2_data;
   logic        o_ID_rs1_busy;
   logic        o_ID_rs2_busy;
   logic        i_ID_issue_valid;
   logic [4:0]  i_ID_issue_rd;
   logic        o_ID_sb_full;
   logic        i_flush;
   logic [63:0] o_a0;

   modport master (
      output i_WB_RegWrite, i_WB_reg_wr_addr, i_WB_reg_wr_data,
      output i_ID_rs1_addr, i_ID_rs2_addr,
      output i_ID_issue_valid, i_ID_issue_rd, i_flush,
      input  o_ID_rs1_data, o_ID_rs2_data,
      input  o_ID_rs1_busy, o_ID_rs2_busy,
      input  o_ID_sb_full, o_a0
   );

   modport slave (
      input  i_WB_RegWrite, i_WB_reg_wr_addr, i_WB_reg_wr_data,
      input  i_ID_rs1_addr, i_ID_rs2_addr,
      input  i_ID_issue_valid, i_ID_issue_rd, i_flush,
      output o_ID_rs1_data, o_ID_rs2_data,
      output o_ID_rs1_busy, o_ID_rs2_busy,
      output o_ID_sb_full, o_a0
   );
endinterface

// File: rtl/ysyx_22040386_regfile_sb.sv
// Integer register file (x1..x31) with writeback bypass and a
// per-register pending-write counter for RAW hazard detection.
module ysyx_22040386_regfile_sb #(
   parameter int PEND_W = 2
) (
   input logic                         clk,
   input logic                         rst_n,
   ysyx_22040386_regfile_sb_if.slave   bus
);
   localparam logic [PEND_W-1:0] PMAX = '1;
   localparam logic [PEND_W-1:0] PONE = PEND_W'(1);

   logic [63:0]       regs [1:31];
   logic [PEND_W-1:0] pend [1:31];

   logic              wr;
   logic [4:0]        wa;
   logic [PEND_W-1:0] p1, p2, pi;
   logic              issue_ok;
   logic [31:1]       inc, dec;

   assign wa = bus.i_WB_reg_wr_addr;
   assign wr = bus.i_WB_RegWrite && (wa != 5'd0);

   always_comb begin
      p1 = '0;
      p2 = '0;
      pi = '0;
      if (bus.i_ID_rs1_addr != 5'd0) p1 = pend[bus.i_ID_rs1_addr];
      if (bus.i_ID_rs2_addr != 5'd0) p2 = pend[bus.i_ID_rs2_addr];
      if (bus.i_ID_issue_rd != 5'd0) pi = pend[bus.i_ID_issue_rd];
   end

   always_comb begin
      bus.o_ID_rs1_data = 64'd0;
      bus.o_ID_rs2_data = 64'd0;
      if (bus.i_ID_rs1_addr != 5'd0) begin
         if (wr && wa == bus.i_ID_rs1_addr)
            bus.o_ID_rs1_data = bus.i_WB_reg_wr_data;
         else
            bus.o_ID_rs1_data = regs[bus.i_ID_rs1_addr];
      end
      if (bus.i_ID_rs2_addr != 5'd0) begin
         if (wr && wa == bus.i_ID_rs2_addr)
            bus.o_ID_rs2_data = bus.i_WB_reg_wr_data;
         else
            bus.o_ID_rs2_data = regs[bus.i_ID_rs2_addr];
      end
   end

   // The last outstanding write landing this cycle is covered by bypass.
   assign bus.o_ID_rs1_busy = (p1 != '0) &&
      !(wr && wa == bus.i_ID_rs1_addr && p1 == PONE);
   assign bus.o_ID_rs2_busy = (p2 != '0) &&
      !(wr && wa == bus.i_ID_rs2_addr && p2 == PONE);

   assign bus.o_ID_sb_full = bus.i_ID_issue_valid &&
      (bus.i_ID_issue_rd != 5'd0) && (pi == PMAX);
   assign issue_ok = bus.i_ID_issue_valid &&
      (bus.i_ID_issue_rd != 5'd0) && !bus.o_ID_sb_full;
   assign bus.o_a0 = regs[10];

   always_comb begin
      inc = '0;
      dec = '0;
      for (int r = 1; r < 32; r++) begin
         inc[r] = issue_ok && (bus.i_ID_issue_rd == 5'(r));
         dec[r] = wr && (wa == 5'(r)) && (pend[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < 32; r++) regs[r] <= 64'd0;
      end else if (wr) begin
         regs[wa] <= bus.i_WB_reg_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < 32; r++) pend[r] <= '0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (bus.i_flush)
               pend[r] <= '0;
            else if (inc[r] && !dec[r])
               pend[r] <= pend[r] + PONE;
            else if (dec[r] && !inc[r])
               pend[r] <= pend[r] - PONE;
         end
      end
   end
endmodule

// File: doc/ysyx_22040386_regfile_sb.md
# ysyx_22040386_regfile_sb

Integer register file with a pending-write scoreboard. It is the receiving end of the writeback interface: it consumes the register write from writeback and serves two combinational read ports to decode. It also tracks in-flight writes per architectural register, so decode can detect read-after-write hazards. Writes issued through the same writeback path include CSR read data.

## Interface
- PEND_W, 2, width of the per-register pending-write counter; max in-flight writes per register = 2^PEND_W-1
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_WB_RegWrite  input  1  writeback write enable
- i_WB_reg_wr_addr  input  5  writeback destination register
- i_WB_reg_wr_data  input  64  writeback data
- i_ID_rs1_addr  input  5  read port 1 address
- i_ID_rs2_addr  input  5  read port 2 address
- o_ID_rs1_data  output  64  read port 1 data
- o_ID_rs2_data  output  64  read port 2 data
- o_ID_rs1_busy  output  1  rs1 has an outstanding write
- o_ID_rs2_busy  output  1  rs2 has an outstanding write
- i_ID_issue_valid  input  1  an instruction writing a register is issued this cycle
- i_ID_issue_rd  input  5  destination of the issued instruction
- o_ID_sb_full  output  1  pending counter of i_ID_issue_rd is at max; the issue must be held
- i_flush  input  1  pipeline flush; clears all pending counters
- o_a0  output  64  current x10 value, used by the halt/ebreak check

## Operation
- Storage: x1..x31, 64 bits each. x0 is not stored; it always reads 0.
- Write: on a clock edge with i_WB_RegWrite=1 and addr≠0, regs[addr] <= data.
  - A write to x0 is discarded.
- Read: combinational. Data is 0 for addr 0.
- Bypass: if i_WB_RegWrite=1, addr≠0 and addr equals the read address in the same cycle, the read returns i_WB_reg_wr_data, not the stored value.
- Pending counter pend[r], r=1..31, PEND_W bits. pend[0] is constantly 0.
  - inc = i_ID_issue_valid && i_ID_issue_rd≠0 && !o_ID_sb_full.
  - dec = i_WB_RegWrite && i_WB_reg_wr_addr≠0 && pend[addr]≠0.
  - Same register, inc and dec in the same cycle: counter unchanged.
  - dec with pend=0: counter stays 0 (no underflow); the data write still happens.
  - inc when pend=max is blocked by o_ID_sb_full; no wrap.
- o_ID_sb_full = i_ID_issue_valid && i_ID_issue_rd≠0 && pend[i_ID_issue_rd]==max. It is combinational.
- Busy for read address a, combinational:
  - asserted when pend[a]≠0;
  - except when this cycle's writeback targets a and pend[a]==1; the bypass then supplies final data and busy is 0.
  - a=0: busy is always 0.
- Flush: on an edge with i_flush=1, all pend <= 0.
  - Flush takes priority over inc/dec in that cycle.
  - The writeback data write in the flush cycle still occurs.
- o_a0 = regs[10] as stored; not bypassed.

## Timing
- Reset (rst_n low, asynchronous): all regs and all pend clear to 0 immediately, independent of clk.
  - Resulting outputs: o_ID_rs*_data=0 (absent bypass), o_ID_rs*_busy=0, o_a0=0.
  - o_ID_sb_full is combinational: 0 while pend=0.
  - Release of rst_n is synchronous to the design; the first update happens at the first clk edge with rst_n high.
- Reset asserted mid-operation: all pending state is lost. An in-progress write at that edge is not performed.
- Write latency: data visible on read ports the same cycle via bypass; from stored registers from the next cycle.
- Scoreboard latency:
  - issue at edge N -> busy visible from cycle N+1;
  - matching writeback in cycle M -> busy drops combinationally in cycle M if pend was 1.
- No handshakes beyond o_ID_sb_full. Decode must hold issue while it is high.

## Test plan
- Reset, then read all 32 addresses on both ports -> all data 0, busy 0, o_a0=0.
- Write x5=0x1122334455667788 and read x5 in the same cycle -> bypass returns 0x1122334455667788; next cycle stored value matches. Write x0=0xFFFF… -> x0 reads 0.
- Issue rd=7 three times (PEND_W=2) -> busy from the next cycle; the 4th issue sees o_ID_sb_full=1 and pend stays 3. Three writebacks to x7 -> busy clears in the cycle of the third writeback.
- Issue rd=9 and writeback x9 in the same cycle with pend[9]=1 -> pend stays 1 and busy stays 1 next cycle. Writeback to x12 with pend=0 -> data written, pend stays 0.
- Issue rd=3 twice, then assert i_flush together with a writeback to x3=0xAB -> next cycle pend[3]=0, busy 0, x3 reads 0xAB.
- Drop rst_n asynchronously between edges with x10=0x55 and pend[10]=2 -> o_a0 and busy go 0 immediately without a clock edge.
